mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle MIPS control FSM with retired-instruction counter
//               and optional trap on undefined opcodes.
// Revision    : 1.0
// ============================================================================
module mips_multicycle_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic [1:0]  pc_source,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // fetch_gate/zero_gate mark the two states whose pc_en follows an input
    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_source;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
        logic       fetch_gate;
        logic       zero_gate;
    } ctrl_t;

    function automatic ctrl_t f_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.alu_src_b  = 2'b01;
                c.fetch_gate = 1'b1;
            end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_source = 2'b01;
                c.zero_gate = 1'b1;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_en     = 1'b1;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
            end
            S_I_WB:  c.reg_write = 1'b1;
            S_TRAP:  c.illegal   = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      r_state;
    ctrl_t       r_ctrl;
    logic [31:0] r_retired;
    state_t      w_next;
    logic        w_retire;
    logic        w_unused_funct;

    assign w_unused_funct = ^funct;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_OP_RTYPE:         w_next = S_R_EXEC;
                    c_OP_LW, c_OP_SW:   w_next = S_MEM_ADDR;
                    c_OP_BEQ:           w_next = S_BRANCH;
                    c_OP_J:             w_next = S_JUMP;
                    c_OP_ADDI, c_OP_ANDI,
                    c_OP_ORI, c_OP_SLTI: w_next = S_I_EXEC;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            w_next = S_TRAP;
                        end else begin
                            w_next   = S_FETCH;
                            w_retire = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: w_next = (opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_R_EXEC: w_next = S_R_WB;
            S_I_EXEC: w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctrl    <= f_ctrl(S_FETCH);
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_ctrl(w_next);
            if (w_retire) r_retired <= r_retired + 32'd1;
        end
    end

    assign pc_en      = r_ctrl.pc_en | (r_ctrl.fetch_gate & mem_ready)
                      | (r_ctrl.zero_gate & zero);
    assign ir_write   = r_ctrl.fetch_gate & mem_ready;
    assign pc_source  = r_ctrl.pc_source;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign i_or_d     = r_ctrl.i_or_d;
    assign reg_write  = r_ctrl.reg_write;
    assign reg_dst    = r_ctrl.reg_dst;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign alu_src_a  = r_ctrl.alu_src_a;
    assign alu_src_b  = r_ctrl.alu_src_b;
    assign alu_op     = r_ctrl.alu_op;
    assign illegal    = r_ctrl.illegal;
    assign state      = r_state;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Randomized scoreboard bench for mips_multicycle_ctrl (trap and
//               NOP-on-illegal variants), with an instruction-level model.
// Revision    : 1.0
// ============================================================================
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, n_rst_n;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;

    logic        pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        n_pc_en, n_ir_write, n_mem_read, n_mem_write, n_i_or_d, n_reg_write;
    logic        n_reg_dst, n_mem_to_reg, n_alu_src_a, n_illegal;
    logic [1:0]  n_pc_source, n_alu_src_b, n_alu_op;
    logic [3:0]  n_state;
    logic [31:0] n_retired;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_source(pc_source),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state), .illegal(illegal), .retired(retired)
    );

    mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst_n(n_rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(n_pc_en), .pc_source(n_pc_source),
        .ir_write(n_ir_write), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .i_or_d(n_i_or_d), .reg_write(n_reg_write), .reg_dst(n_reg_dst),
        .mem_to_reg(n_mem_to_reg), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
        .alu_op(n_alu_op), .state(n_state), .illegal(n_illegal), .retired(n_retired)
    );

    typedef struct {
        bit          sel;
        int          st;
        logic [19:0] v;
        logic [31:0] r;
    } entry_t;

    entry_t      sb[$];
    int          plist[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          sel = 1'b0;
    logic [31:0] m_retired = '0;
    logic [5:0]  legal_ops [9] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02,
                                   6'h08, 6'h0c, 6'h0d, 6'h0a};

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [5:0] rand_legal();
        return legal_ops[$urandom_range(0, 8)];
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
        return op;
    endfunction

    // Expected control outputs for a given state, straight from the state table
    function automatic logic [19:0] exp_vec(input int st, input logic mr, input logic z);
        logic       pe, irw, rd, wr, iod, rw, rdst, m2r, sa, ill;
        logic [1:0] ps, sbv, op;
        logic [3:0] s4;
        {pe, irw, rd, wr, iod, rw, rdst, m2r, sa, ill} = '0;
        {ps, sbv, op} = '0;
        s4 = st[3:0];
        case (st)
            0:  begin rd = 1; sbv = 2'b01; irw = mr; pe = mr; end
            1:  sbv = 2'b11;
            2:  begin sa = 1; sbv = 2'b10; end
            3:  begin rd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin wr = 1; iod = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin sa = 1; op = 2'b01; ps = 2'b01; pe = z; end
            9:  begin ps = 2'b10; pe = 1; end
            10: begin sa = 1; sbv = 2'b10; op = 2'b11; end
            11: rw = 1;
            12: ill = 1;
            default: ;
        endcase
        return {s4, pe, ps, irw, rd, wr, iod, rw, rdst, m2r, sa, sbv, op, ill};
    endfunction

    function automatic logic [19:0] act_vec(input bit s);
        if (s)
            return {n_state, n_pc_en, n_pc_source, n_ir_write, n_mem_read, n_mem_write,
                    n_i_or_d, n_reg_write, n_reg_dst, n_mem_to_reg, n_alu_src_a,
                    n_alu_src_b, n_alu_op, n_illegal};
        return {state, pc_en, pc_source, ir_write, mem_read, mem_write, i_or_d,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};
    endfunction

    task automatic check(input string nm, input logic [19:0] av, input logic [19:0] ev,
                         input logic [31:0] ar, input logic [31:0] er);
        vectors++;
        if (av !== ev || ar !== er) begin
            miscompares++;
            $display("FAIL %s: got ctrl=%05h retired=%08h, expected ctrl=%05h retired=%08h",
                     nm, av, ar, ev, er);
        end
    endtask

    // Instruction-level model: the sequence of states each class walks through
    task automatic build_phases(input logic [5:0] op);
        plist.delete();
        plist.push_back(0);
        plist.push_back(1);
        case (op)
            6'h23:   begin plist.push_back(2); plist.push_back(3); plist.push_back(4); end
            6'h2b:   begin plist.push_back(2); plist.push_back(5); end
            6'h00:   begin plist.push_back(6); plist.push_back(7); end
            6'h04:   plist.push_back(8);
            6'h02:   plist.push_back(9);
            6'h08, 6'h0c, 6'h0d, 6'h0a: begin plist.push_back(10); plist.push_back(11); end
            default: ;
        endcase
    endtask

    task automatic drive_push(input logic [5:0] op, input logic mr, input int zval, input int p);
        entry_t e;
        opcode    = op;
        mem_ready = mr;
        zero      = (zval < 0) ? 1'($urandom_range(0, 1)) : 1'(zval);
        funct     = 6'($urandom_range(0, 63));
        e.sel = sel;
        e.st  = p;
        e.v   = exp_vec(p, mr, zero);
        e.r   = m_retired;
        sb.push_back(e);
    endtask

    task automatic step(input logic [5:0] op, input logic mr, input int zval, input int p);
        drive_push(op, mr, zval, p);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset in the middle of the current cycle, checked before any edge
    task automatic do_abort();
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        m_retired = '0;
        check("async reset", act_vec(1'b0), exp_vec(0, 1'b0, zero), retired, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int abort_at, input int stalls,
                             input int zval);
        build_phases(op);
        for (int i = 0; i < plist.size(); i++) begin
            int p;
            int n;
            bit w;
            p = plist[i];
            w = (p == 0 || p == 3 || p == 5);
            n = w ? ((stalls >= 0) ? stalls : int'($urandom_range(0, 2))) : 0;
            for (int k = 0; k < n; k++) step(op, 1'b0, zval, p);
            if (i == abort_at) begin
                drive_push(op, w ? 1'b1 : 1'($urandom_range(0, 1)), zval, p);
                do_abort();
                return;
            end
            step(op, w ? 1'b1 : 1'($urandom_range(0, 1)), zval, p);
        end
        if (!is_legal(op) && !sel) begin
            int nt;
            nt = 10 + int'($urandom_range(0, 2));
            for (int k = 0; k < nt; k++) step(op, 1'($urandom_range(0, 1)), zval, 12);
            drive_push(op, 1'($urandom_range(0, 1)), zval, 12);
            do_abort();
            return;
        end
        m_retired = m_retired + 32'd1;
    endtask

    initial begin : monitor
        entry_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("dut%0d state %0d", e.sel, e.st), act_vec(e.sel), e.v,
                      e.sel ? n_retired : retired, e.r);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0; n_rst_n = 1'b0;
        opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(6'h23, 1'b0, -1, 0);
        step(6'h2b, 1'b0, -1, 0);
        rst_n = 1'b1;

        run_instr(6'h23, -1, 0, -1);
        run_instr(6'h2b, -1, 3, -1);
        run_instr(6'h04, -1, 0, 1);
        run_instr(6'h04, -1, 0, 0);
        run_instr(6'h00, 3, 0, -1);
        run_instr(6'h08, -1, -1, -1);
        run_instr(6'h0d, -1, -1, -1);
        run_instr(6'h02, -1, -1, -1);

        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        m_retired = 32'hFFFF_FFFF;
        run_instr(6'h02, -1, 0, -1);

        for (int i = 0; i < 150; i++) begin
            logic [5:0] op;
            int         ab;
            op = ($urandom_range(0, 19) == 0) ? rand_illegal() : rand_legal();
            ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, ab, -1, -1);
        end
        run_instr(6'h3f, -1, 0, -1);

        rst_n     = 1'b0;
        n_rst_n   = 1'b1;
        sel       = 1'b1;
        m_retired = '0;
        run_instr(6'h3f, -1, 0, -1);
        for (int i = 0; i < 60; i++)
            run_instr(($urandom_range(0, 2) == 0) ? rand_illegal() : rand_legal(), -1, -1, -1);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
